// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter. After reset it clears the memory, then
// arbitrates between the CPU pipeline (port 0) and the loader/debug port
// (port 1) on a round-robin basis, one access per cycle.
module dmem_arbiter #(
    parameter int RAM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic                  err0,
    output logic                  err1,
    output logic                  cpu_stall,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic                  mem_write_en,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] DEPTH     = ADDR_WIDTH'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  last_gnt;   // 1 = port 1 granted most recently

    logic                  any_gnt;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  in_range;

    // Next state, grant decision and memory port drive.
    always_comb begin
        state_next     = state;
        gnt0           = 1'b0;
        gnt1           = 1'b0;
        mem_read_addr  = '0;
        mem_write_addr = '0;
        mem_write_en   = 1'b0;
        mem_write_data = '0;

        sel_we    = gnt1 ? we1 : we0;
        sel_addr  = addr0;
        sel_wdata = wdata0;

        case (state)
            INIT: begin
                mem_write_addr = clr_cnt;
                mem_write_en   = reset_b;
                if (clr_cnt == LAST_ADDR) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // On a tie the port that did not win last time goes first.
                gnt0 = req0 & (~req1 | last_gnt);
                gnt1 = req1 & (~req0 | ~last_gnt);
            end
            default: state_next = INIT;
        endcase

        any_gnt   = gnt0 | gnt1;
        sel_we    = gnt1 ? we1 : we0;
        sel_addr  = gnt1 ? addr1 : addr0;
        sel_wdata = gnt1 ? wdata1 : wdata0;
        in_range  = sel_addr < DEPTH;

        if (any_gnt && in_range) begin
            mem_read_addr  = sel_addr;
            mem_write_addr = sel_addr;
            mem_write_en   = sel_we & reset_b;
            mem_write_data = sel_wdata;
        end
    end

    assign cpu_stall = (state == INIT) | (req0 & ~gnt0);
    assign init_done = (state == RUN);

    // State register, clear counter and round-robin history.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state    <= INIT;
            clr_cnt  <= '0;
            last_gnt <= 1'b1;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (any_gnt) begin
                last_gnt <= gnt1;
            end
        end
    end

    // Registered read return and one-cycle status pulses per port.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rdata0  <= '0;
            rdata1  <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~we0 & in_range;
            rvalid1 <= gnt1 & ~we1 & in_range;
            err0    <= gnt0 & ~in_range;
            err1    <= gnt1 & ~in_range;
            if (gnt0 && !we0 && in_range) begin
                rdata0 <= mem_read_data;
            end
            if (gnt1 && !we1 && in_range) begin
                rdata1 <= mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with RAM_DEPTH=16: directed scenarios plus random
// two-port traffic, compared every cycle against a rule-level model.
module tb_dmem_arbiter;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic        cpu_stall, init_done, mem_write_en;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.RAM_DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset_b(reset_b),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .err0(err0), .err1(err1),
        .cpu_stall(cpu_stall), .init_done(init_done),
        .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
        .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Environment memory, preloaded with junk so the clear is observable.
    logic [31:0] ram [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) ram[i] = 32'hBAD0_0000 + i;
    assign mem_read_data = (mem_read_addr < DEPTH) ? ram[mem_read_addr[3:0]] : 32'h0BAD_0BAD;
    always @(posedge clk)
        if (mem_write_en && mem_write_addr < DEPTH) ram[mem_write_addr[3:0]] <= mem_write_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_cyc = 0;        // rising edges since reset release
    int          m_last = 1;       // port granted most recently
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rdata [2];
    bit          m_rvalid [2];
    bit          m_err [2];
    bit          m_took [2];       // port granted at the latest edge

    initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    function automatic int pick(input logic r0, input logic r1, input int last);
        if (r0 && r1) return 1 - last;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge reset_b) begin : model
        int          g;
        logic [31:0] a;
        if (!reset_b) begin
            m_cyc = 0; m_last = 1;
            for (int p = 0; p < 2; p++) begin
                m_rdata[p] = '0; m_rvalid[p] = 0; m_err[p] = 0; m_took[p] = 0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                m_rvalid[p] = 0; m_err[p] = 0; m_took[p] = 0;
            end
            if (m_cyc >= DEPTH) begin
                g = pick(req0, req1, m_last);
                if (g >= 0) begin
                    m_took[g] = 1;
                    m_last    = g;
                    a = (g == 1) ? addr1 : addr0;
                    if (a < DEPTH) begin
                        if ((g == 1) ? we1 : we0)
                            m_mem[a[3:0]] = (g == 1) ? wdata1 : wdata0;
                        else begin
                            m_rdata[g]  = m_mem[a[3:0]];
                            m_rvalid[g] = 1;
                        end
                    end else begin
                        m_err[g] = 1;
                    end
                end
            end else begin
                m_mem[m_cyc] = '0;
            end
            if (m_cyc < 1000) m_cyc++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin : cmp
        int          g;
        logic [31:0] a, wd;
        logic        w, run, ok;
        run = (m_cyc >= DEPTH);
        g   = run ? pick(req0, req1, m_last) : -1;
        a   = (g == 1) ? addr1 : addr0;
        wd  = (g == 1) ? wdata1 : wdata0;
        w   = (g == 1) ? we1 : we0;
        ok  = (g >= 0) && (a < DEPTH);
        chk("gnt0", gnt0, g == 0);
        chk("gnt1", gnt1, g == 1);
        chk("cpu_stall", cpu_stall, !run || (req0 && g != 0));
        chk("init_done", init_done, run);
        chk("mem_write_en", mem_write_en, reset_b && (!run || (ok && w)));
        if (!run && reset_b) begin
            chk("clr_addr", mem_write_addr, m_cyc);
            chk("clr_data", mem_write_data, 0);
        end
        if (ok) begin
            chk("rd_addr", mem_read_addr, a);
            chk("wr_addr", mem_write_addr, a);
            chk("wr_data", mem_write_data, wd);
        end
        if (run && g < 0) begin
            chk("idle_rd_addr", mem_read_addr, 0);
            chk("idle_wr_addr", mem_write_addr, 0);
        end
        chk("rdata0", rdata0, m_rdata[0]);
        chk("rdata1", rdata1, m_rdata[1]);
        chk("rvalid0", rvalid0, m_rvalid[0]);
        chk("rvalid1", rvalid1, m_rvalid[1]);
        chk("err0", err0, m_err[0]);
        chk("err1", err1, m_err[1]);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Follows a reset release through the whole clear with req0 held high.
    task automatic init_walk();
        int n_wen;
        n_wen = 0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (mem_write_en) n_wen++;
            chk("lit_init_done", init_done, k == 17);
            if (k <= 16) begin
                chk("lit_init_gnt0", gnt0, 0);
                chk("lit_init_addr", mem_write_addr, k - 1);
            end
            if (k == 16) begin
                #1 req0 = 0; req1 = 0;
            end
        end
        chk("lit_init_wen_cycles", n_wen, 16);
        tick();
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h8000_0000 | 32'($urandom_range(0, 15));
        if (r == 1) return 32'(DEPTH + $urandom_range(0, 3));
        return 32'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        bit p0, p1;
        reset_b = 0;
        req0 = 1; we0 = 0; addr0 = 3;
        repeat (3) tick();
        @(negedge clk);
        chk("lit_rst_gnt0", gnt0, 0);
        chk("lit_rst_stall", cpu_stall, 1);
        chk("lit_rst_wen", mem_write_en, 0);
        chk("lit_rst_done", init_done, 0);
        tick();
        reset_b = 1;
        init_walk();

        // Tie for four cycles: port 0 first, then alternate.
        req0 = 1; we0 = 0; addr0 = 1;
        req1 = 1; we1 = 0; addr1 = 2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lit_rr_gnt0", gnt0, (k % 2) == 0);
            chk("lit_rr_stall", cpu_stall, (k % 2) == 1);
            tick();
        end
        req0 = 0; req1 = 0;
        tick();

        // Write then read back on port 0.
        req0 = 1; we0 = 1; addr0 = 5; wdata0 = 32'hDEADBEEF;
        @(negedge clk); chk("lit_wr_gnt0", gnt0, 1);
        tick();
        we0 = 0;
        @(negedge clk); chk("lit_rd_gnt0", gnt0, 1);
        tick();
        req0 = 0;
        @(negedge clk);
        chk("lit_rd_rvalid0", rvalid0, 1);
        chk("lit_rd_rdata0", rdata0, 32'hDEADBEEF);
        tick();

        // Out-of-range read on port 1.
        req1 = 1; we1 = 0; addr1 = 16;
        @(negedge clk);
        chk("lit_oor_gnt1", gnt1, 1);
        chk("lit_oor_wen", mem_write_en, 0);
        tick();
        req1 = 0;
        @(negedge clk);
        chk("lit_oor_err1", err1, 1);
        chk("lit_oor_rvalid1", rvalid1, 0);
        chk("lit_oor_rdata1", rdata1, 0);
        tick();

        // Random traffic; each requester holds until its grant.
        p0 = 0; p1 = 0;
        for (int n = 0; n < 400; n++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1; req0 = 1; we0 = ($urandom_range(0, 1) == 1);
                addr0 = rand_addr(); wdata0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1; req1 = 1; we1 = ($urandom_range(0, 1) == 1);
                addr1 = rand_addr(); wdata1 = $urandom;
            end
            tick();
            if (m_took[0]) begin p0 = 0; req0 = 0; end
            if (m_took[1]) begin p1 = 0; req1 = 0; end
        end
        req0 = 0; req1 = 0;
        tick();

        // Reset in the middle of the clear, at clr_cnt == 7.
        reset_b = 0;
        tick();
        reset_b = 1;
        req0 = 1; we0 = 0;
        repeat (7) tick();
        reset_b = 0;
        @(negedge clk);
        chk("lit_midclr_wen", mem_write_en, 0);
        chk("lit_midclr_stall", cpu_stall, 1);
        chk("lit_midclr_done", init_done, 0);
        tick();
        reset_b = 1;
        init_walk();

        // Reset right after a granted read: the pulse must vanish.
        req0 = 1; we0 = 0; addr0 = 5;
        tick();
        reset_b = 0;
        req0 = 0;
        #1;
        chk("lit_abort_rvalid0", rvalid0, 0);
        chk("lit_abort_rdata0", rdata0, 0);
        tick();
        reset_b = 1;
        req0 = 1;
        init_walk();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
